sram_arbiter: RTL

- Shares one asynchronous 512Kx8 SRAM bank (19-bit address, 8-bit data, active-low CE/OE/WE) among three requesters: port 0 = video fetch, port 1 = audio fetch, port 2 = CPU/loader.
- Arbitrates between the requesters, then sequences read and write cycles with programmable wait states.
- Instantiated once per bank at top level; the bidirectional data pins are built at top level from sram_dout/sram_doe/sram_din.

---
 rtl/sram_arbiter_if.sv | 31 +++
 rtl/sram_arbiter.sv | 126 ++++++++++++
 2 files changed

// File: rtl/sram_arbiter_if.sv
// Requester-side handshake and SRAM pin bundle for one sram_arbiter bank.
// master = requesters plus SRAM model; slave = the arbiter.
interface sram_arbiter_if #(
  parameter int AddrBits = 19
);
  logic [2:0]          rq_req;
  logic [2:0]          rq_we;
  logic [AddrBits-1:0] rq0_addr, rq1_addr, rq2_addr;
  logic [7:0]          rq0_wdata, rq1_wdata, rq2_wdata;
  logic [2:0]          rq_ack;
  logic [7:0]          rdata;
  logic [AddrBits-1:0] sram_addr;
  logic [7:0]          sram_dout;
  logic                sram_doe;
  logic [7:0]          sram_din;
  logic                sram_ce_n, sram_oe_n, sram_we_n;

  modport master (
    output rq_req, rq_we, rq0_addr, rq1_addr, rq2_addr,
           rq0_wdata, rq1_wdata, rq2_wdata, sram_din,
    input  rq_ack, rdata, sram_addr, sram_dout, sram_doe,
           sram_ce_n, sram_oe_n, sram_we_n
  );

  modport slave (
    input  rq_req, rq_we, rq0_addr, rq1_addr, rq2_addr,
           rq0_wdata, rq1_wdata, rq2_wdata, sram_din,
    output rq_ack, rdata, sram_addr, sram_dout, sram_doe,
           sram_ce_n, sram_oe_n, sram_we_n
  );
endinterface

// File: rtl/sram_arbiter.sv
// Three-port fixed-priority arbiter for one async 512Kx8 SRAM bank with
// programmable strobe width. Every output comes straight from a register.
module sram_arbiter #(
  parameter int WaitStates = 1,
  parameter int AddrBits   = 19
) (
  input  logic          clock,
  input  logic          reset,
  sram_arbiter_if.slave bus
);
  typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD} state_t;
  localparam logic [3:0] WS = 4'(WaitStates);

  state_t                   state_q, state_d;
  logic [3:0]               cnt_q, cnt_d;
  logic [2:0]               gnt_q, gnt_d, ack_q, ack_d, elig;
  logic [1:0]               sel;
  logic [AddrBits-1:0]      addr_q, addr_d;
  logic [7:0]               dout_q, dout_d, rdata_q, rdata_d;
  logic                     doe_q, doe_d, ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
  logic [2:0][AddrBits-1:0] rq_addr;
  logic [2:0][7:0]          rq_wdata;

  assign rq_addr  = {bus.rq2_addr, bus.rq1_addr, bus.rq0_addr};
  assign rq_wdata = {bus.rq2_wdata, bus.rq1_wdata, bus.rq0_wdata};
  // A port still holding req during its own ack cycle must not win again.
  assign elig     = bus.rq_req & ~ack_q;
  assign sel      = elig[0] ? 2'd0 : (elig[1] ? 2'd1 : 2'd2);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    ack_d   = '0;
    addr_d  = addr_q;
    dout_d  = dout_q;
    doe_d   = doe_q;
    ce_n_d  = ce_n_q;
    oe_n_d  = oe_n_q;
    we_n_d  = we_n_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (|elig) begin
        gnt_d  = 3'b001 << sel;
        addr_d = rq_addr[sel];
        ce_n_d = 1'b0;
        cnt_d  = WS;
        if (bus.rq_we[sel]) begin
          state_d = WR_SETUP;
          dout_d  = rq_wdata[sel];
          doe_d   = 1'b1;
        end else begin
          state_d = RD;
          oe_n_d  = 1'b0;
        end
      end
      RD: if (cnt_q == 4'd0) begin
        rdata_d = bus.sram_din;
        state_d = IDLE;
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        ack_d   = gnt_q;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
      WR_SETUP: begin
        state_d = WR_PULSE;
        we_n_d  = 1'b0;
        cnt_d   = WS;
      end
      WR_PULSE: if (cnt_q == 4'd0) begin
        state_d = WR_HOLD;
        we_n_d  = 1'b1;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
      WR_HOLD: begin
        state_d = IDLE;
        ce_n_d  = 1'b1;
        doe_d   = 1'b0;
        ack_d   = gnt_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      addr_q  <= '0;
      dout_q  <= '0;
      rdata_q <= '0;
      doe_q   <= 1'b0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      rdata_q <= rdata_d;
      doe_q   <= doe_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
    end
  end

  assign bus.rq_ack    = ack_q;
  assign bus.rdata     = rdata_q;
  assign bus.sram_addr = addr_q;
  assign bus.sram_dout = dout_q;
  assign bus.sram_doe  = doe_q;
  assign bus.sram_ce_n = ce_n_q;
  assign bus.sram_oe_n = oe_n_q;
  assign bus.sram_we_n = we_n_q;
endmodule
